counter_ctrl_sched: RTL and testbench

Bus-side controller for the 3-channel counter block. It accepts CPU register writes and queues them in a small command FIFO. It issues them to the counter one at a time on counter_we/counter_ch/counter_val, and holds off between loads so the slow counter clock domains can latch each load. It also synchronises the three counter OUT lines, latches their rising edges as sticky status bits and raises an interrupt.

---
 rtl/counter_ctrl_sched.sv | 195 +++++++++++++++++++
 tb/tb_counter_ctrl_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_ctrl_sched.sv
// Bus-side command scheduler and OUT-line status/interrupt logic for the 3-channel counter.
// Optional irq mask register at addr 7 is built when COUNTER_IRQ_MASK_EN is defined.
module counter_ctrl_sched #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [2:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic        counter_we,
  output logic [1:0]  counter_ch,
  output logic [31:0] counter_val,
  input  logic        counter0_OUT,
  input  logic        counter1_OUT,
  input  logic        counter2_OUT,
  input  logic [31:0] counter_out,
  output logic        irq
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HW = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  typedef struct packed {
    logic [1:0]  ch;
    logic [31:0] val;
  } cmd_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;

  cmd_t          fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          cmd_write;
  logic          fifo_push;
  logic          fifo_pop;
  cmd_t          fifo_head;

  logic [2:0]    out_raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    sync3;
  logic [2:0]    out_rise;
  logic [2:0]    sticky;
  logic [2:0]    sticky_clr;
  logic [2:0]    sticky_nxt;
  logic [2:0]    irq_mask_nxt;

  logic          busy;
  logic [31:0]   status_word;
  logic [31:0]   rdata_nxt;

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);
  assign cmd_write  = bus_we && !bus_addr[2];
  assign fifo_pop   = (state == IDLE) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign fifo_push  = cmd_write && (!fifo_full || fifo_pop);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign bus_ready  = bus_addr[2] ? 1'b1 : !fifo_full;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr] <= '{ch: bus_addr[1:0], val: bus_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue scheduler: one pulse per command, then a hold window after channel loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      counter_we  <= 1'b0;
      counter_ch  <= '0;
      counter_val <= '0;
    end else begin
      counter_we <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_pop) begin
            counter_ch  <= fifo_head.ch;
            counter_val <= fifo_head.val;
            counter_we  <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (counter_ch != 2'd3) begin
            hold_cnt <= HW'(HOLD_CYCLES - 1);
            state    <= HOLD;
          end else begin
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_raw    = {counter2_OUT, counter1_OUT, counter0_OUT};
  assign out_rise   = sync2 & ~sync3;
  assign sticky_clr = (bus_we && (bus_addr == 3'd5)) ? bus_wdata[2:0] : 3'b000;
  assign sticky_nxt = (sticky & ~sticky_clr) | out_rise;

`ifdef COUNTER_IRQ_MASK_EN
  logic [2:0] irq_mask;

  assign irq_mask_nxt = (bus_we && (bus_addr == 3'd7)) ? bus_wdata[2:0] : irq_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_mask <= 3'b111;
    end else begin
      irq_mask <= irq_mask_nxt;
    end
  end
`else
  assign irq_mask_nxt = 3'b111;
`endif

  // irq follows the next sticky/mask values so it updates on the same edge as sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      sync3  <= '0;
      sticky <= '0;
      irq    <= 1'b0;
    end else begin
      sync1  <= out_raw;
      sync2  <= sync1;
      sync3  <= sync2;
      sticky <= sticky_nxt;
      irq    <= |(sticky_nxt & irq_mask_nxt);
    end
  end

  assign busy        = (state != IDLE) || !fifo_empty;
  assign status_word = {16'b0, 8'(fifo_count), 4'b0, busy, sticky};

  always_comb begin
    rdata_nxt = '0;
    case (bus_addr)
      3'd4: rdata_nxt = status_word;
      3'd6: rdata_nxt = counter_out;
`ifdef COUNTER_IRQ_MASK_EN
      3'd7: rdata_nxt = {29'b0, irq_mask};
`endif
      default: rdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      bus_rdata <= rdata_nxt;
    end
  end

endmodule

// File: tb/tb_counter_ctrl_sched.sv
// Directed bench for counter_ctrl_sched with hand-computed expectations (default parameters).
module tb_counter_ctrl_sched;

  logic        clk;
  logic        rst;
  logic        bus_we;
  logic        bus_re;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [31:0] counter_val;
  logic        counter0_OUT;
  logic        counter1_OUT;
  logic        counter2_OUT;
  logic [31:0] counter_out;
  logic        irq;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;

  int          log_cyc [$];
  logic [1:0]  log_ch  [$];
  logic [31:0] log_val [$];

  int          exp_off [5];
  logic [1:0]  exp_ch  [5];
  logic [31:0] exp_val [5];

  counter_ctrl_sched #(.FIFO_DEPTH(4), .HOLD_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .bus_we(bus_we), .bus_re(bus_re), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .counter_we(counter_we), .counter_ch(counter_ch), .counter_val(counter_val),
    .counter0_OUT(counter0_OUT), .counter1_OUT(counter1_OUT), .counter2_OUT(counter2_OUT),
    .counter_out(counter_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse log: cycle index of the edge that raised counter_we, plus ch/val.
  always @(negedge clk) begin
    if (counter_we === 1'b1) begin
      log_cyc.push_back(cyc);
      log_ch.push_back(counter_ch);
      log_val.push_back(counter_val);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_we    = 1'b1;
    bus_addr  = addr;
    bus_wdata = data;
    tick();
    bus_we    = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] addr);
    bus_re   = 1'b1;
    bus_addr = addr;
    tick();
    bus_re   = 1'b0;
  endtask

  task automatic check_log(input string tag, input int s, input int base);
    check({tag, "_n"}, 32'(log_cyc.size() - s), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (s + i < log_cyc.size()) begin
        check($sformatf("%s_cyc%0d", tag, i), 32'(log_cyc[s+i] - base), 32'(exp_off[i]));
        check($sformatf("%s_ch%0d", tag, i), 32'(log_ch[s+i]), 32'(exp_ch[i]));
        check($sformatf("%s_val%0d", tag, i), log_val[s+i], exp_val[i]);
      end
    end
  endtask

  initial begin
    int s;
    int base;
    rst = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = 3'd0; bus_wdata = '0;
    counter0_OUT = 1'b0; counter1_OUT = 1'b0; counter2_OUT = 1'b0; counter_out = '0;

    // Reset state
    tick(); tick();
    check("rst_we", 32'(counter_we), 32'd0);
    check("rst_ch", 32'(counter_ch), 32'd0);
    check("rst_val", counter_val, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_ready", 32'(bus_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Single channel load: latency 2, one-cycle pulse, busy through the hold window
    bus_write(3'd1, 32'h0000_0100);
    check("t1_lat1", 32'(counter_we), 32'd0);
    tick();
    check("t1_we", 32'(counter_we), 32'd1);
    check("t1_ch", 32'(counter_ch), 32'd1);
    check("t1_val", counter_val, 32'h100);
    tick();
    check("t1_we_off", 32'(counter_we), 32'd0);
    check("t1_ch_hold", 32'(counter_ch), 32'd1);
    repeat (7) tick();
    bus_re = 1'b1; bus_addr = 3'd4;
    tick();
    check("t1_busy_last", bus_rdata, 32'h0000_0008);
    tick();
    check("t1_busy_clear", bus_rdata, 32'h0000_0000);
    bus_re = 1'b0;

    // Back-to-back writes: channel loads 10 apart, control writes 2 apart
    s = log_cyc.size();
    bus_write(3'd0, 32'd10);
    base = cyc;
    bus_write(3'd1, 32'd20);
    bus_write(3'd2, 32'd30);
    bus_write(3'd3, 32'h6);
    bus_write(3'd3, 32'h7);
    repeat (40) tick();
    exp_off = '{1, 11, 21, 31, 33};
    exp_ch  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    exp_val = '{32'd10, 32'd20, 32'd30, 32'h6, 32'h7};
    check_log("t2", s, base);

    // Fill FIFO while held in HOLD; fifth write dropped
    s = log_cyc.size();
    bus_write(3'd0, 32'h1);
    base = cyc;
    tick(); tick();
    bus_write(3'd0, 32'h11);
    bus_write(3'd1, 32'h12);
    bus_write(3'd2, 32'h13);
    bus_write(3'd3, 32'h14);
    bus_we = 1'b1; bus_addr = 3'd2; bus_wdata = 32'h55;
    #1;
    check("t3_ready_full", 32'(bus_ready), 32'd0);
    tick();
    bus_we = 1'b0;
    bus_re = 1'b1; bus_addr = 3'd4;
    #1;
    check("t3_ready_stat", 32'(bus_ready), 32'd1);
    tick();
    bus_re = 1'b0;
    check("t3_status", bus_rdata, 32'h0000_0408);
    repeat (60) tick();
    exp_off = '{1, 11, 21, 31, 41};
    exp_ch  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_val = '{32'h1, 32'h11, 32'h12, 32'h13, 32'h14};
    check_log("t3", s, base);

    // OUT2 rising edge -> sticky[2] and irq after 3 clocks; W1C behaviour
    counter2_OUT = 1'b1;
    tick(); tick();
    check("t4_irq_early", 32'(irq), 32'd0);
    tick();
    check("t4_irq_set", 32'(irq), 32'd1);
    bus_read(3'd4);
    check("t4_sticky", bus_rdata, 32'h0000_0004);
    bus_write(3'd5, 32'h3);
    check("t4_irq_wrong_clr", 32'(irq), 32'd1);
    bus_write(3'd5, 32'h4);
    check("t4_irq_clr", 32'(irq), 32'd0);
    bus_read(3'd4);
    check("t4_sticky_clr", bus_rdata, 32'h0000_0000);
    counter2_OUT = 1'b0;
    repeat (3) tick();
    counter2_OUT = 1'b1;
    tick(); tick();
    bus_write(3'd5, 32'h4);
    check("t4_irq_setwins", 32'(irq), 32'd1);
    bus_read(3'd4);
    check("t4_sticky_setwins", bus_rdata, 32'h0000_0004);
    bus_write(3'd5, 32'h4);
    check("t4_irq_final", 32'(irq), 32'd0);

    // Read paths
    counter_out = 32'hDEAD_BEEF;
    bus_read(3'd6);
    check("t5_cnt", bus_rdata, 32'hDEAD_BEEF);
    bus_addr = 3'd4; counter_out = 32'h0;
    tick();
    check("t5_hold", bus_rdata, 32'hDEAD_BEEF);
    bus_read(3'd4);
    check("t5_idle", bus_rdata, 32'h0);
    bus_read(3'd7);
`ifdef COUNTER_IRQ_MASK_EN
    check("t5_addr7", bus_rdata, 32'h7);
`else
    check("t5_addr7", bus_rdata, 32'h0);
`endif
    bus_read(3'd5);
    check("t5_addr5", bus_rdata, 32'h0);
    bus_write(3'd6, 32'h1);
    bus_read(3'd4);
    check("t5_wr6_ign", bus_rdata, 32'h0);

    // Reset mid-HOLD with two queued commands
    s = log_cyc.size();
    counter_out = 32'h1234;
    bus_write(3'd0, 32'hA);
    counter1_OUT = 1'b1;
    tick();
    check("t6_we", 32'(counter_we), 32'd1);
    tick();
    bus_write(3'd1, 32'hB);
    bus_write(3'd2, 32'hC);
    check("t6_irq_pre", 32'(irq), 32'd1);
    bus_read(3'd6);
    check("t6_rdata_pre", bus_rdata, 32'h1234);
    rst = 1'b1; counter1_OUT = 1'b0;
    tick();
    check("t6_we_rst", 32'(counter_we), 32'd0);
    check("t6_ch_rst", 32'(counter_ch), 32'd0);
    check("t6_val_rst", counter_val, 32'd0);
    check("t6_irq_rst", 32'(irq), 32'd0);
    check("t6_rdata_rst", bus_rdata, 32'd0);
    rst = 1'b0;
    bus_read(3'd4);
    check("t6_status", bus_rdata, 32'h0);
    repeat (30) tick();
    check("t6_pulses", 32'(log_cyc.size() - s), 32'd1);

`ifdef COUNTER_IRQ_MASK_EN
    // Mask gates irq without hiding sticky
    bus_write(3'd7, 32'h1);
    bus_read(3'd7);
    check("t7_mask", bus_rdata, 32'h1);
    counter1_OUT = 1'b1;
    repeat (3) tick();
    check("t7_irq_masked", 32'(irq), 32'd0);
    bus_read(3'd4);
    check("t7_sticky", bus_rdata, 32'h2);
    bus_write(3'd7, 32'h2);
    check("t7_irq_unmask", 32'(irq), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
